// File: rtl/seg_pkg.sv
// Shared types and the active-low hex font for the seven-segment display controller.
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bit0..6 = a..g, bit7 = dp; a 0 lights the segment, dp always dark.
    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_disp_ctrl_if.sv
// Load port of the display controller: valid/ready handshake plus the value to load.
interface seg_disp_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      i_load_valid;
    logic                      o_load_ready;
    logic [4*NUM_DIGITS-1:0]   i_load_data;

    modport master (output i_load_valid, output i_load_data, input o_load_ready);
    modport slave  (input i_load_valid, input i_load_data, output o_load_ready);
endinterface

// File: rtl/seg_hex_decoder.sv
// One digit of the display: nibble to active-low segment byte, forced dark when blanked.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [7:0] o_seg
);
    assign o_seg = i_blank ? SEG_OFF : hex2seg(i_nib);
endmodule

// File: rtl/seg_disp_ctrl.sv
// N-digit seven-segment controller: loadable hex value stepped on a divided tick.
// Optional blinking of masked digits is built when SEG_BLINK_EN is defined.
module seg_disp_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int TICK_DIV    = 5000000,
    parameter int BLINK_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    seg_disp_ctrl_if.slave          lif,
    input  logic [1:0]              i_mode,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic                    o_tick,
    output logic [8*NUM_DIGITS-1:0] o_seg
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0]           r_div;
    logic [VW-1:0]           r_value;
    logic                    r_ready;
    logic [8*NUM_DIGITS-1:0] r_seg;

    logic                    w_tick;
    logic                    w_load;
    logic [VW-1:0]           w_rot;
    logic [VW-1:0]           w_value_nxt;
    logic [NUM_DIGITS-1:0]   w_dark;
    logic [8*NUM_DIGITS-1:0] w_seg_nxt;

    assign w_tick = (r_div == DW'(TICK_DIV - 1));
    assign w_load = lif.i_load_valid && r_ready;

    generate
        if (NUM_DIGITS == 1) begin : g_rot1
            assign w_rot = r_value;
        end else begin : g_rotn
            assign w_rot = {r_value[VW-5:0], r_value[VW-1 -: 4]};
        end
    endgenerate

    // A load in the tick cycle takes priority and suppresses that step.
    always_comb begin
        w_value_nxt = r_value;
        if (w_load) begin
            w_value_nxt = lif.i_load_data;
        end else if (w_tick) begin
            case (mode_e'(i_mode))
                MODE_UP:     w_value_nxt = r_value + VW'(1);
                MODE_DOWN:   w_value_nxt = r_value - VW'(1);
                MODE_ROTATE: w_value_nxt = w_rot;
                default:     w_value_nxt = r_value;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div   <= '0;
            r_value <= '0;
            r_ready <= 1'b0;
            r_seg   <= '1;
        end else begin
            r_ready <= 1'b1;
            r_value <= w_value_nxt;
            r_div   <= (w_load || w_tick) ? '0 : r_div + DW'(1);
            r_seg   <= w_seg_nxt;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS + 1) : 1;

    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    always_ff @(posedge clk) begin
        if (!resetn || w_load) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    assign w_dark = i_blank_mask | (i_blink_mask & {NUM_DIGITS{r_phase}});
`else
    // Blink mask and period stay on the port list for drop-in compatibility only.
    logic w_unused_blink;
    assign w_unused_blink = ^{i_blink_mask, BLINK_TICKS[0]};
    assign w_dark = i_blank_mask;
`endif

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
            seg_hex_decoder u_dec (
                .i_nib   (r_value[4*k +: 4]),
                .i_blank (w_dark[k]),
                .o_seg   (w_seg_nxt[8*k +: 8])
            );
        end
    endgenerate

    assign lif.o_load_ready = r_ready;
    assign o_value          = r_value;
    assign o_tick           = w_tick;
    assign o_seg            = r_seg;
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl (8 digits, 4-cycle tick) with a queue of expected results.
module tb_seg_disp_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  blank = 8'h00;
    logic [7:0]  blink = 8'h00;
    logic [31:0] value;
    logic        tick;
    logic [63:0] seg;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    seg_disp_ctrl_if #(.NUM_DIGITS(8)) lif ();

    seg_disp_ctrl #(.NUM_DIGITS(8), .TICK_DIV(4), .BLINK_TICKS(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .lif          (lif),
        .i_mode       (mode),
        .i_blank_mask (blank),
        .i_blink_mask (blink),
        .o_value      (value),
        .o_tick       (tick),
        .o_seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] d, input logic [1:0] m);
        lif.i_load_valid = 1'b1;
        lif.i_load_data  = d;
        mode             = m;
        step();
        lif.i_load_valid = 1'b0;
    endtask

    // Advance to the cycle holding o_tick, without crossing its edge.
    task automatic find_tick(input string tag);
        int n = 0;
        while (!tick && n < 20) begin
            step();
            n++;
        end
        if (!tick) chk({tag, "_timeout"}, {63'b0, tick}, 64'd1);
    endtask

    // Cross the next tick edge, then pop and compare the stepped value.
    task automatic sb_value(input string tag);
        logic [63:0] e;
        find_tick(tag);
        step();
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {32'b0, value}, e);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v);
        return {v[27:0], v[31:28]};
    endfunction

    initial begin
        int n;
        logic [31:0] r;
        lif.i_load_valid = 1'b0;
        lif.i_load_data  = '0;

        // Reset state
        step(); step(); step();
        chk("rst_value", {32'b0, value}, 64'd0);
        chk("rst_seg", seg, {64{1'b1}});
        chk("rst_ready", {63'b0, lif.o_load_ready}, 64'd0);
        chk("rst_tick", {63'b0, tick}, 64'd0);
        resetn = 1'b1;
        step();
        chk("rel_ready", {63'b0, lif.o_load_ready}, 64'd1);
        step();
        chk("rel_seg_zero", seg, {8{8'hC0}});

        // HOLD
        load(32'h0123_4567, 2'b00);
        chk("hold_load", {32'b0, value}, 64'h0123_4567);
        step();
        chk("hold_seg", seg, 64'hC0F9A4B0_999282F8);
        for (int i = 0; i < 20; i++) exp_q.push_back(64'h0123_4567);
        for (int i = 0; i < 20; i++) sb_value("hold_tick");

        // UP across the all-F wrap, plus tick period
        load(32'hFFFF_FFFE, 2'b01);
        exp_q.push_back(64'hFFFF_FFFF);
        exp_q.push_back(64'h0000_0000);
        sb_value("up_tick1");
        sb_value("up_wrap");
        step();
        chk("up_wrap_seg", seg, {8{8'hC0}});
        find_tick("period");
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 20);
        chk("tick_period", 64'(n), 64'd4);

        // ROTATE through a full cycle
        load(32'h1234_5678, 2'b11);
        r = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            r = rotl(r);
            exp_q.push_back({32'b0, r});
        end
        sb_value("rot_1");
        for (int i = 1; i < 8; i++) sb_value("rot_n");
        chk("rot_back", {32'b0, value}, 64'h1234_5678);

        // DOWN from zero
        load(32'h0, 2'b10);
        exp_q.push_back(64'hFFFF_FFFF);
        sb_value("down_wrap");
        step();
        chk("down_seg", seg, {8{8'h8E}});

        // Load lands in the tick cycle
        load(32'h0000_0010, 2'b01);
        find_tick("ld_tick");
        lif.i_load_valid = 1'b1;
        lif.i_load_data  = 32'hAAAA_5555;
        step();
        lif.i_load_valid = 1'b0;
        chk("ld_tick_value", {32'b0, value}, 64'hAAAA_5555);
        n = 1;
        while (!tick && n < 20) begin
            step();
            n++;
        end
        chk("ld_tick_next", 64'(n), 64'd4);
        exp_q.push_back(64'hAAAA_5556);
        sb_value("ld_tick_step");

        // Reset mid-count, with a load pending
        step();
        resetn = 1'b0;
        lif.i_load_valid = 1'b1;
        lif.i_load_data  = 32'h7777_7777;
        step();
        chk("midrst_value", {32'b0, value}, 64'd0);
        chk("midrst_seg", seg, {64{1'b1}});
        chk("midrst_ready", {63'b0, lif.o_load_ready}, 64'd0);
        lif.i_load_valid = 1'b0;
        resetn = 1'b1;
        step();
        step();
        chk("midrst_drop", {32'b0, value}, 64'd0);

        // Blanking
        blank = 8'h0F;
        load(32'h8888_8888, 2'b00);
        step();
        chk("blank_seg", seg, 64'h80808080_FFFFFFFF);
        blank = 8'h00;

        // Blinking digit 7
        blink = 8'h80;
        load(32'h8888_8888, 2'b00);
`ifdef SEG_BLINK_EN
        exp_q.push_back(64'h80);
        exp_q.push_back(64'hFF);
        exp_q.push_back(64'hFF);
        exp_q.push_back(64'h80);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h80);
`endif
        for (int i = 0; i < 4; i++) begin
            logic [63:0] e;
            find_tick("blink");
            step();
            step();
            e = exp_q.pop_front();
            chk("blink_byte7", {56'b0, seg[63:56]}, e);
            chk("blink_byte0", {56'b0, seg[7:0]}, 64'h80);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
Parametrised N-digit seven-segment display controller. It is the successor to the fixed 8-digit seg block on the board top. It holds a hex value loaded over a valid/ready port and either keeps it static or steps it on a divided time base: count up, count down, or rotate. It drives active-low segment patterns for every digit, with per-digit blanking.

Parameters:
NUM_DIGITS, 8, number of hex digits / segment outputs (1..8)
TICK_DIV, 5000000, clk cycles per step tick (>=2)
BLINK_TICKS, 2, step ticks per blink half-period (used only with SEG_BLINK_EN)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
i_load_valid  in  1  load request
o_load_ready  out  1  load port ready
i_load_data  in  4*NUM_DIGITS  value to load; nibble k = digit k
i_mode  in  2  00 HOLD, 01 UP, 10 DOWN, 11 ROTATE
i_blank_mask  in  NUM_DIGITS  1 = digit k dark
i_blink_mask  in  NUM_DIGITS  1 = digit k blinks (ignored without SEG_BLINK_EN)
o_value  out  4*NUM_DIGITS  current internal value
o_tick  out  1  one-cycle step pulse
o_seg  out  8*NUM_DIGITS  byte k = digit k; bit0..6 = a..g, bit7 = dp; active-low

Behaviour:
- Reset (resetn=0 at a clk edge): value=0, divider=0, o_tick=0, o_load_ready=0, o_seg all 1s (every segment off), blink phase=0.
- o_load_ready rises the first cycle after resetn is sampled high and stays 1 until the next reset.
- Load accepted when i_load_valid && o_load_ready. o_value equals i_load_data on the next cycle. The divider restarts at 0 on the same edge.
- Divider counts 0..TICK_DIV-1 and wraps. o_tick=1 for exactly the cycle in which the divider equals TICK_DIV-1. The divider free-runs in every mode.
- On a tick, the value steps according to i_mode sampled in that cycle:
  - HOLD: no change.
  - UP: +1 modulo 2^(4N); all-F wraps to 0.
  - DOWN: -1 modulo 2^(4N); 0 wraps to all-F.
  - ROTATE: left-rotate by one nibble; the top nibble moves to digit 0.
- Load and tick in the same cycle: load wins, no step is applied, divider restarts.
- A mode change takes effect at the next tick. It does not restart the divider.
- o_seg is registered, so it lags o_value by 1 cycle.
- Blanked digit: byte = 8'hFF. Otherwise byte = hex font with dp off (bit7=1).
- Font examples: 0=C0, 1=F9, 8=80, A=88, F=8E.
- i_blank_mask is applied combinationally into the o_seg register, with the same 1-cycle latency.
- Reset mid-operation: all state returns to reset values on that edge. A pending load is dropped.

Optional Feature:
SEG_BLINK_EN
- Defined: a blink phase register toggles every BLINK_TICKS ticks. It is cleared on load and on reset. While phase=1, digits whose i_blink_mask bit is 1 output 8'hFF. Blanking overrides blinking.
- Not defined: no blink logic; i_blink_mask is ignored and the port remains for interface stability.

Decomposition:
- Package seg_pkg holds:
  - mode enum (HOLD/UP/DOWN/ROTATE)
  - SEG_OFF = 8'hFF
  - the 16-entry active-low font function hex2seg
- Sub-module seg_hex_decoder: combinational, one per digit (generate loop). Nibble plus blank in, 8-bit pattern out.
- The controller itself holds the divider, value register, handshake, and output register.

Test Plan:
- Reset release, NUM_DIGITS=8: cycle 0 -> o_seg all FF, o_load_ready=0. Cycle 1 -> ready=1. Cycle 2 -> all bytes C0.
- Load 32'h0123_4567, HOLD, TICK_DIV=4: next cycle o_value=01234567. One cycle later byte0=F8 ("7"), byte7=C0. Value unchanged over 20 ticks.
- Load 32'hFFFF_FFFE, UP, TICK_DIV=4: after tick 1 value FFFFFFFF; after tick 2 value 00000000, all bytes C0. o_tick period is exactly 4 cycles.
- Load 32'h1234_5678, ROTATE: after one tick value 23456781; after 8 ticks back to 12345678. DOWN from 0: one tick gives FFFFFFFF, all bytes 8E.
- Load asserted in the o_tick cycle, UP: value equals the loaded data (no +1); next tick is 4 cycles later. Reset asserted mid-count: next cycle value 0, o_seg FF.
- i_blank_mask=8'h0F with value 88888888: bytes 0-3 = FF, bytes 4-7 = 80. With SEG_BLINK_EN, BLINK_TICKS=2, i_blink_mask=8'h80: byte7 alternates 80/FF every 2 ticks.
